// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector (x/en/overlap/load/pat_in/clr_cnt in; registered z, saturating match_count, active pattern out)
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               en,
  input  logic               overlap,
  input  logic               load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr_cnt,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic [PAT_LEN-1:0] pattern
);
  localparam int FW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-1:0] hist, win;
  logic [FW-1:0] fill;
  logic hit;
  always_comb begin
    win = {hist[PAT_LEN-2:0], x};
    hit = en && !load && win == pattern && fill >= FW'(PAT_LEN - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      pattern <= PAT_RESET;
      z <= 1'b0;
      match_count <= '0;
    end else begin
      if (load) begin
        pattern <= pat_in;
        fill <= '0;
      end else if (en) begin
        hist <= win;
        fill <= (hit && !overlap) ? '0 : (fill == FW'(PAT_LEN)) ? fill : fill + 1'b1;
      end
      z <= hit;
      match_count <= clr_cnt ? '0 : (hit && !(&match_count)) ? match_count + 1'b1 : match_count;
    end
  end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench for seq_detector_param with a 2-bit counter
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic reset, x, en, overlap, load, clr_cnt;
  logic [3:0] pat_in;
  logic z;
  logic [1:0] match_count;
  logic [3:0] pattern;
  typedef struct packed {
    logic z;
    logic [1:0] cnt;
    logic [3:0] pat;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  logic [3:0] epat = 4'b1011;
  seq_detector_param #(.PAT_LEN(4), .PAT_RESET(4'b1011), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .load(load),
    .pat_in(pat_in), .clr_cnt(clr_cnt), .z(z), .match_count(match_count), .pattern(pattern)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic xi, input logic ei, input logic li, input logic ci,
                      input logic ri, input logic [3:0] pi, input logic ez, input string tag);
    exp_t e;
    @(negedge clk);
    x = xi; en = ei; load = li; clr_cnt = ci; reset = ri; pat_in = pi;
    if (ri) begin
      epat = 4'b1011;
      ecnt = 0;
    end else begin
      if (li) epat = pi;
      ecnt = ci ? 0 : (ez && ecnt < 3) ? ecnt + 1 : ecnt;
    end
    e.z = ez && !ri && !li;
    e.cnt = ecnt[1:0];
    e.pat = epat;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, "_z"}, z, e.z);
    check({tag, "_cnt"}, match_count, e.cnt);
    check({tag, "_pat"}, pattern, e.pat);
  endtask
  task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] zmask, input string tag);
    for (int i = 0; i < n; i++) step(bits[i], 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, zmask[i], $sformatf("%s_b%0d", tag, i));
  endtask
  task automatic do_reset(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, tag);
  endtask
  // bit i of each vector is the i-th serial bit / expected z after it
  localparam logic [31:0] S1 = 32'b0110_1001_1011_0100;
  localparam logic [31:0] S3 = 32'b0110_1101;
  initial begin
    reset = 1'b1; x = 1'b0; en = 1'b0; overlap = 1'b0; load = 1'b0; clr_cnt = 1'b0; pat_in = 4'b0;
    do_reset("rst0");
    do_reset("rst1");
    overlap = 1'b0;
    stream(S1, 16, 32'h0000_4020, "nonov");
    check("nonov_final", match_count, 2);
    do_reset("rst2");
    overlap = 1'b1;
    stream(S1, 16, 32'h0000_4120, "ov");
    check("ov_final", match_count, 3);
    do_reset("rst3");
    overlap = 1'b1;
    stream(S3, 7, 32'h48, "cmp_ov");
    do_reset("rst4");
    overlap = 1'b0;
    stream(S3, 7, 32'h08, "cmp_nov");
    do_reset("rst5");
    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, "load");
    stream(32'h3f, 6, 32'h38, "ones");
    check("ones_pat", pattern, 4'b1111);
    stream(32'h3, 2, 32'h3, "sat");
    check("sat_hold", match_count, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0, 1'b1, "clr_hit");
    check("clr_cnt", match_count, 0);
    check("clr_z", z, 1);
    do_reset("rst6");
    overlap = 1'b0;
    stream(32'b101, 3, 32'h0, "en_pre");
    for (int i = 0; i < 3; i++) step(i[0], 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, $sformatf("idle%0d", i));
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, "en_hit");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, "en_after");
    check("en_count", match_count, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, "load2");
    stream(32'b10, 2, 32'h0, "mid");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0, 1'b0, "midrst");
    check("midrst_pat", pattern, 4'b1011);
    check("midrst_cnt", match_count, 0);
    if (q.size() != 0) check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
